// File: rtl/dmem_pkg.sv
// dmem_pkg: shared encodings for the byte-lane data memory controller.
//   - access size encodings (byte / half / word / reserved)
//   - lane count
//   - controller state encoding
//   - size_bytes(): number of bytes touched by an access size
package dmem_pkg;

  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {
    SIZE_B   = 2'd0,
    SIZE_H   = 2'd1,
    SIZE_W   = 2'd2,
    SIZE_RSV = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_RSP     = 2'd2
  } state_e;

  // Reserved size touches no bytes, so it naturally produces no strobes.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_B:  return 3'd1;
      SIZE_H:  return 3'd2;
      SIZE_W:  return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_rotator.sv
// dmem_lane_rotator: combinational lane mapping for the byte-lane BRAMs.
//   addr/size/wdata   : incoming request -> per-lane address, enable, write byte
//   rd_off/rd_size/rd_unsigned/lane_dout : latched load info + raw lane bytes
//                                          -> rotated and extended load data
//   lane_addr  : lane l = {row_l, 2'(l)}
//   lane_en    : lanes touched by the request
//   lane_din   : write byte per lane, 0 on untouched lanes
//   rdata      : formatted load data
module dmem_lane_rotator
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 13
) (
  input  logic [ADDR_WIDTH-1:0]           addr,
  input  logic [1:0]                      size,
  input  logic [31:0]                     wdata,
  input  logic [1:0]                      rd_off,
  input  logic [1:0]                      rd_size,
  input  logic                            rd_unsigned,
  input  logic [31:0]                     lane_dout,
  output logic [NUM_LANES*ADDR_WIDTH-1:0] lane_addr,
  output logic [NUM_LANES-1:0]            lane_en,
  output logic [31:0]                     lane_din,
  output logic [31:0]                     rdata
);

  localparam int RW = ADDR_WIDTH - 2;

  logic [1:0]    off;
  logic [RW-1:0] row;
  logic [2:0]    nb;
  logic [1:0]    lane_j  [NUM_LANES];
  logic [1:0]    rd_lane [NUM_LANES];
  logic [RW-1:0] row_l   [NUM_LANES];
  logic [31:0]   raw;

  function automatic logic [31:0] extend_load(input logic [31:0] v, input logic [1:0] sz,
                                              input logic uns);
    case (sz)
      SIZE_B:  return {{24{~uns & v[7]}}, v[7:0]};
      SIZE_H:  return {{16{~uns & v[15]}}, v[15:0]};
      SIZE_W:  return v;
      default: return 32'd0;
    endcase
  endfunction

  assign off = addr[1:0];
  assign row = addr[ADDR_WIDTH-1:2];
  assign nb  = size_bytes(size);

  always_comb begin
    lane_addr = '0;
    lane_en   = '0;
    lane_din  = '0;
    raw       = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      // Lane k carries request byte j = (k - off) mod 4; it is used when j < n.
      lane_j[k]  = 2'(k) - off;
      lane_en[k] = {1'b0, lane_j[k]} < nb;
      // A used lane below the start offset holds a byte that spilled into the next row.
      row_l[k]   = row + RW'(lane_en[k] && (2'(k) < off));
      lane_addr[k*ADDR_WIDTH +: ADDR_WIDTH] = {row_l[k], 2'(k)};
      if (lane_en[k]) lane_din[8*k +: 8] = wdata[{lane_j[k], 3'b000} +: 8];
      // Load byte k comes from lane (off + k) mod 4.
      rd_lane[k] = 2'(k) + rd_off;
      raw[8*k +: 8] = lane_dout[{rd_lane[k], 3'b000} +: 8];
    end
    rdata = extend_load(raw, rd_size, rd_unsigned);
  end

endmodule

// File: rtl/dmem_lane_ctrl.sv
// dmem_lane_ctrl: load/store initiator for four 8-bit byte-lane data BRAMs.
//   REQ_*     : core request (valid/ready), store/load, size, sign, byte address, store data
//   RSP_*     : one-entry load response buffer (valid/ready)
//   LANE_ADDR : per-lane {row, lane} address, shared by BRAM read and write ports
//   LANE_WE/RE: per-lane strobes, high only in the cycle after acceptance
//   LANE_DIN  : per-lane write bytes; LANE_DOUT: per-lane read bytes (valid from negedge)
module dmem_lane_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 13
) (
  input  logic                            CLK,
  input  logic                            RST_N,
  input  logic                            REQ_VALID,
  output logic                            REQ_READY,
  input  logic                            REQ_WE,
  input  logic [1:0]                      REQ_SIZE,
  input  logic                            REQ_UNSIGNED,
  input  logic [ADDR_WIDTH-1:0]           REQ_ADDR,
  input  logic [31:0]                     REQ_WDATA,
  output logic                            RSP_VALID,
  input  logic                            RSP_READY,
  output logic [31:0]                     RSP_RDATA,
  output logic [NUM_LANES*ADDR_WIDTH-1:0] LANE_ADDR,
  output logic [NUM_LANES-1:0]            LANE_WE,
  output logic [NUM_LANES-1:0]            LANE_RE,
  output logic [31:0]                     LANE_DIN,
  input  logic [31:0]                     LANE_DOUT
);

  state_e                          state_p0;
  logic [1:0]                      rd_off_p0;
  logic [1:0]                      rd_size_p0;
  logic                            rd_uns_p0;
  logic                            accept;
  logic [NUM_LANES*ADDR_WIDTH-1:0] rot_addr;
  logic [NUM_LANES-1:0]            rot_en;
  logic [31:0]                     rot_din;
  logic [31:0]                     rot_rdata;

  dmem_lane_rotator #(.ADDR_WIDTH(ADDR_WIDTH)) u_rot (
    .addr        (REQ_ADDR),
    .size        (REQ_SIZE),
    .wdata       (REQ_WDATA),
    .rd_off      (rd_off_p0),
    .rd_size     (rd_size_p0),
    .rd_unsigned (rd_uns_p0),
    .lane_dout   (LANE_DOUT),
    .lane_addr   (rot_addr),
    .lane_en     (rot_en),
    .lane_din    (rot_din),
    .rdata       (rot_rdata)
  );

  // Held low during reset; in RSP a request can only enter when the response retires.
  assign REQ_READY = RST_N && ((state_p0 == ST_IDLE) || ((state_p0 == ST_RSP) && RSP_READY));
  assign accept    = REQ_VALID && REQ_READY;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_p0  <= ST_IDLE;
      RSP_VALID <= 1'b0;
      RSP_RDATA <= '0;
      LANE_WE   <= '0;
      LANE_RE   <= '0;
      LANE_ADDR <= '0;
      LANE_DIN  <= '0;
    end else begin
      // Stage p0: request issue to the lanes
      LANE_WE <= '0;
      LANE_RE <= '0;
      if (accept) begin
        LANE_ADDR  <= rot_addr;
        LANE_DIN   <= REQ_WE ? rot_din : '0;
        rd_off_p0  <= REQ_ADDR[1:0];
        rd_size_p0 <= REQ_SIZE;
        rd_uns_p0  <= REQ_UNSIGNED;
        if (REQ_WE) LANE_WE <= rot_en;
        else        LANE_RE <= rot_en;
      end
      // Stage p1: read capture and response hand-off
      case (state_p0)
        ST_IDLE: begin
          if (accept && !REQ_WE) state_p0 <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          RSP_RDATA <= rot_rdata;
          RSP_VALID <= 1'b1;
          state_p0  <= ST_RSP;
        end
        ST_RSP: begin
          if (RSP_READY) begin
            RSP_VALID <= 1'b0;
            state_p0  <= (accept && !REQ_WE) ? ST_RD_WAIT : ST_IDLE;
          end
        end
        default: state_p0 <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_lane_ctrl.sv
module tb_dmem_lane_ctrl;
  localparam int AW = 13;
  localparam int NB = 1 << AW;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          REQ_VALID = 1'b0;
  logic          REQ_READY;
  logic          REQ_WE = 1'b0;
  logic [1:0]    REQ_SIZE = 2'd0;
  logic          REQ_UNSIGNED = 1'b0;
  logic [AW-1:0] REQ_ADDR = '0;
  logic [31:0]   REQ_WDATA = '0;
  logic          RSP_VALID;
  logic          RSP_READY = 1'b1;
  logic [31:0]   RSP_RDATA;
  logic [4*AW-1:0] LANE_ADDR;
  logic [3:0]    LANE_WE, LANE_RE;
  logic [31:0]   LANE_DIN;
  logic [31:0]   LANE_DOUT;

  int checks = 0;
  int fails  = 0;

  logic [7:0]  ref_mem [NB];
  logic [7:0]  bram [4][NB/4];
  logic [31:0] dout_r = '0;
  assign LANE_DOUT = dout_r;

  dmem_lane_ctrl #(.ADDR_WIDTH(AW)) dut (
    .CLK(CLK), .RST_N(RST_N), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_WE(REQ_WE), .REQ_SIZE(REQ_SIZE), .REQ_UNSIGNED(REQ_UNSIGNED),
    .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .RSP_VALID(RSP_VALID),
    .RSP_READY(RSP_READY), .RSP_RDATA(RSP_RDATA), .LANE_ADDR(LANE_ADDR),
    .LANE_WE(LANE_WE), .LANE_RE(LANE_RE), .LANE_DIN(LANE_DIN), .LANE_DOUT(LANE_DOUT)
  );

  always #5 CLK = ~CLK;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Lane BRAMs: sample on negedge, row = lane address above the lane bits.
  always @(negedge CLK) begin
    if ((|LANE_WE) || (|LANE_RE)) begin
      checks++;
      if ((|LANE_WE) && (|LANE_RE)) begin
        fails++;
        $display("FAIL strobe_overlap: we=%h re=%h, required one of them 0", LANE_WE, LANE_RE);
      end
    end
    for (int l = 0; l < 4; l++) begin
      if (LANE_WE[l] === 1'b1) bram[l][LANE_ADDR[l*AW+2 +: AW-2]] <= LANE_DIN[8*l +: 8];
      if (LANE_RE[l] === 1'b1) dout_r[8*l +: 8] <= bram[l][LANE_ADDR[l*AW+2 +: AW-2]];
    end
  end

  // ---------------- reference model (byte-addressed memory) ----------------
  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : (s == 2'd2) ? 4 : 0;
  endfunction

  function automatic logic [3:0] exp_mask(input logic [AW-1:0] a, input logic [1:0] s);
    logic [3:0] m = '0;
    logic [AW-1:0] b;
    for (int j = 0; j < nbytes(s); j++) begin
      b = a + AW'(j);
      m[b[1:0]] = 1'b1;
    end
    return m;
  endfunction

  // Each touched byte address b lands on lane b%4 whose lane address is b itself.
  function automatic logic [4*AW-1:0] exp_addr(input logic [AW-1:0] a, input logic [1:0] s);
    logic [4*AW-1:0] r;
    logic [AW-1:0] b;
    for (int l = 0; l < 4; l++) r[l*AW +: AW] = {a[AW-1:2], 2'(l)};
    for (int j = 0; j < nbytes(s); j++) begin
      b = a + AW'(j);
      r[int'(b[1:0])*AW +: AW] = b;
    end
    return r;
  endfunction

  function automatic logic [31:0] exp_din(input logic [AW-1:0] a, input logic [1:0] s,
                                          input logic [31:0] d);
    logic [31:0] r = '0;
    logic [AW-1:0] b;
    for (int j = 0; j < nbytes(s); j++) begin
      b = a + AW'(j);
      r[int'(b[1:0])*8 +: 8] = d[8*j +: 8];
    end
    return r;
  endfunction

  function automatic logic [31:0] model_load(input logic [AW-1:0] a, input logic [1:0] s,
                                             input logic u);
    logic [31:0] v = '0;
    int n = nbytes(s);
    if (n == 0) return 32'd0;
    for (int j = 0; j < n; j++) v[8*j +: 8] = ref_mem[a + AW'(j)];
    if (!u && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
    return v;
  endfunction

  task automatic model_store(input logic [AW-1:0] a, input logic [1:0] s, input logic [31:0] d);
    for (int j = 0; j < nbytes(s); j++) ref_mem[a + AW'(j)] = d[8*j +: 8];
  endtask

  // ---------------- drivers ----------------
  // Called at #1 after a posedge; returns at #1 after the accepting posedge.
  task automatic send(input logic we, input logic [1:0] s, input logic u, input logic [AW-1:0] a,
                      input logic [31:0] d, output bit ok);
    int n = 0;
    REQ_VALID = 1'b1; REQ_WE = we; REQ_SIZE = s; REQ_UNSIGNED = u; REQ_ADDR = a; REQ_WDATA = d;
    while (REQ_READY !== 1'b1 && n < 20) begin
      @(posedge CLK); #1; n++;
    end
    ok = (REQ_READY === 1'b1);
    if (ok) begin
      @(posedge CLK); #1;
      if (we) model_store(a, s, d);
    end
    REQ_VALID = 1'b0;
  endtask

  // Load with RSP_READY=1: v is RSP_VALID one edge after acceptance, then the response retires.
  task automatic run_load(input logic [1:0] s, input logic u, input logic [AW-1:0] a,
                          output bit ok, output logic v, output logic [31:0] d);
    RSP_READY = 1'b1;
    send(1'b0, s, u, a, 32'd0, ok);
    @(posedge CLK); #1;
    v = RSP_VALID; d = RSP_RDATA;
    @(posedge CLK); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checks++; if (REQ_READY !== 1'b0) begin fails++; $display("FAIL rst_ready: got %b need 0", REQ_READY); end
    checks++; if (RSP_VALID !== 1'b0) begin fails++; $display("FAIL rst_rsp_valid: got %b need 0", RSP_VALID); end
    checks++; if (RSP_RDATA !== 32'd0) begin fails++; $display("FAIL rst_rdata: got %h need 0", RSP_RDATA); end
    checks++; if (LANE_WE !== 4'd0 || LANE_RE !== 4'd0) begin fails++; $display("FAIL rst_strobes: we=%h re=%h need 0", LANE_WE, LANE_RE); end
    checks++; if (LANE_ADDR !== '0 || LANE_DIN !== 32'd0) begin fails++; $display("FAIL rst_lane: addr=%h din=%h need 0", LANE_ADDR, LANE_DIN); end
    RST_N = 1'b1;
    #1;
    checks++; if (REQ_READY !== 1'b1) begin fails++; $display("FAIL rst_release_ready: got %b need 1", REQ_READY); end
  endtask

  task automatic test_aligned_word();
    bit ok; logic v; logic [31:0] d;
    send(1'b1, 2'd2, 1'b0, 13'h010, 32'hDEADBEEF, ok);
    checks++; if (!ok) begin fails++; $display("FAIL aw_store_accept: timeout"); end
    checks++; if (LANE_WE !== 4'hF || LANE_RE !== 4'h0) begin fails++; $display("FAIL aw_store_we: we=%h re=%h need F/0", LANE_WE, LANE_RE); end
    checks++; if (LANE_ADDR !== {13'h013, 13'h012, 13'h011, 13'h010}) begin fails++; $display("FAIL aw_store_addr: got %h", LANE_ADDR); end
    checks++; if (LANE_DIN !== 32'hDEADBEEF) begin fails++; $display("FAIL aw_store_din: got %h need deadbeef", LANE_DIN); end
    RSP_READY = 1'b1;
    send(1'b0, 2'd2, 1'b0, 13'h010, 32'd0, ok);
    checks++; if (LANE_RE !== 4'hF || RSP_VALID !== 1'b0) begin fails++; $display("FAIL aw_load_issue: re=%h rsp_valid=%b need F/0", LANE_RE, RSP_VALID); end
    @(posedge CLK); #1;
    checks++; if (RSP_VALID !== 1'b1 || RSP_RDATA !== 32'hDEADBEEF) begin fails++; $display("FAIL aw_load_rsp: valid=%b data=%h need 1/deadbeef", RSP_VALID, RSP_RDATA); end
    @(posedge CLK); #1;
    checks++; if (RSP_VALID !== 1'b0) begin fails++; $display("FAIL aw_load_retire: valid=%b need 0", RSP_VALID); end
    v = 1'b0; d = '0;
  endtask

  task automatic test_misaligned_word();
    bit ok; logic v; logic [31:0] d;
    send(1'b1, 2'd2, 1'b0, 13'h013, 32'h11223344, ok);
    checks++; if (LANE_WE !== 4'hF) begin fails++; $display("FAIL mis_we: got %h need F", LANE_WE); end
    checks++; if (LANE_ADDR !== {13'h013, 13'h016, 13'h015, 13'h014}) begin fails++; $display("FAIL mis_addr: got %h", LANE_ADDR); end
    checks++; if (LANE_DIN !== 32'h44112233) begin fails++; $display("FAIL mis_din: got %h need 44112233", LANE_DIN); end
    run_load(2'd2, 1'b0, 13'h013, ok, v, d);
    checks++; if (!ok || v !== 1'b1 || d !== 32'h11223344) begin fails++; $display("FAIL mis_load: ok=%0d valid=%b data=%h need 11223344", ok, v, d); end
  endtask

  task automatic test_sign_extend();
    bit ok; logic v; logic [31:0] d;
    send(1'b1, 2'd0, 1'b0, 13'h006, 32'h00000080, ok);
    send(1'b1, 2'd0, 1'b0, 13'h007, 32'h00000012, ok);
    run_load(2'd0, 1'b0, 13'h006, ok, v, d);
    checks++; if (v !== 1'b1 || d !== 32'hFFFFFF80) begin fails++; $display("FAIL sx_byte_signed: data=%h need ffffff80", d); end
    run_load(2'd0, 1'b1, 13'h006, ok, v, d);
    checks++; if (v !== 1'b1 || d !== 32'h00000080) begin fails++; $display("FAIL sx_byte_unsigned: data=%h need 00000080", d); end
    run_load(2'd1, 1'b0, 13'h006, ok, v, d);
    checks++; if (v !== 1'b1 || d !== 32'h00001280) begin fails++; $display("FAIL sx_half: data=%h need 00001280", d); end
    run_load(2'd2, 1'b1, 13'h004, ok, v, d);
    checks++; if (d !== model_load(13'h004, 2'd2, 1'b1)) begin fails++; $display("FAIL sx_word_uns: data=%h need %h", d, model_load(13'h004, 2'd2, 1'b1)); end
  endtask

  task automatic test_backpressure();
    bit ok; logic [31:0] held, e2;
    RSP_READY = 1'b0;
    send(1'b0, 2'd2, 1'b0, 13'h010, 32'd0, ok);
    @(posedge CLK); #1;
    held = RSP_RDATA;
    checks++; if (RSP_VALID !== 1'b1 || held !== model_load(13'h010, 2'd2, 1'b0)) begin fails++; $display("FAIL bp_first: valid=%b data=%h", RSP_VALID, held); end
    REQ_VALID = 1'b1; REQ_WE = 1'b0; REQ_SIZE = 2'd1; REQ_UNSIGNED = 1'b1; REQ_ADDR = 13'h013;
    e2 = model_load(13'h013, 2'd1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(posedge CLK); #1;
      checks++;
      if (RSP_VALID !== 1'b1 || RSP_RDATA !== held || REQ_READY !== 1'b0 || LANE_RE !== 4'd0) begin
        fails++;
        $display("FAIL bp_hold%0d: valid=%b data=%h ready=%b re=%h", k, RSP_VALID, RSP_RDATA, REQ_READY, LANE_RE);
      end
    end
    RSP_READY = 1'b1;
    #1;
    checks++; if (REQ_READY !== 1'b1) begin fails++; $display("FAIL bp_ready_follow: got %b need 1", REQ_READY); end
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
    checks++; if (RSP_VALID !== 1'b0 || LANE_RE !== exp_mask(13'h013, 2'd1)) begin fails++; $display("FAIL bp_dual_handshake: valid=%b re=%h", RSP_VALID, LANE_RE); end
    @(posedge CLK); #1;
    checks++; if (RSP_VALID !== 1'b1 || RSP_RDATA !== e2) begin fails++; $display("FAIL bp_second: valid=%b data=%h need %h", RSP_VALID, RSP_RDATA, e2); end
    @(posedge CLK); #1;
  endtask

  task automatic test_wrap();
    bit ok; logic v; logic [31:0] d;
    send(1'b1, 2'd1, 1'b0, 13'h1FFF, 32'h0000A55A, ok);
    checks++; if (LANE_WE !== 4'b1001 || LANE_DIN !== 32'h5A0000A5) begin fails++; $display("FAIL wrap_store: we=%h din=%h", LANE_WE, LANE_DIN); end
    RSP_READY = 1'b1;
    send(1'b0, 2'd1, 1'b0, 13'h1FFF, 32'd0, ok);
    checks++; if (LANE_RE !== 4'b1001) begin fails++; $display("FAIL wrap_re: got %h need 9", LANE_RE); end
    checks++; if (LANE_ADDR[3*AW +: AW] !== 13'h1FFF || LANE_ADDR[0 +: AW] !== 13'h0000) begin fails++; $display("FAIL wrap_addr: lane3=%h lane0=%h", LANE_ADDR[3*AW +: AW], LANE_ADDR[0 +: AW]); end
    @(posedge CLK); #1;
    v = RSP_VALID; d = RSP_RDATA;
    checks++; if (v !== 1'b1 || d !== 32'hFFFFA55A) begin fails++; $display("FAIL wrap_data: valid=%b data=%h need ffffa55a", v, d); end
    @(posedge CLK); #1;
  endtask

  task automatic test_back_to_back();
    REQ_VALID = 1'b1; REQ_WE = 1'b1; REQ_SIZE = 2'd0; REQ_UNSIGNED = 1'b0;
    for (int k = 0; k < 4; k++) begin
      REQ_ADDR = 13'h040 + 13'(k); REQ_WDATA = 32'($urandom);
      @(posedge CLK); #1;
      model_store(REQ_ADDR, 2'd0, REQ_WDATA);
      checks++; if (LANE_WE !== (4'b0001 << k) || LANE_DIN !== exp_din(REQ_ADDR, 2'd0, REQ_WDATA)) begin fails++; $display("FAIL b2b_store%0d: we=%h din=%h", k, LANE_WE, LANE_DIN); end
    end
    REQ_WE = 1'b0; REQ_SIZE = 2'd2; REQ_ADDR = 13'h041; RSP_READY = 1'b1;
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
    checks++; if (LANE_RE !== 4'hF || LANE_WE !== 4'h0) begin fails++; $display("FAIL b2b_load_issue: re=%h we=%h", LANE_RE, LANE_WE); end
    @(posedge CLK); #1;
    checks++; if (RSP_VALID !== 1'b1 || RSP_RDATA !== model_load(13'h041, 2'd2, 1'b0)) begin fails++; $display("FAIL b2b_raw: data=%h need %h", RSP_RDATA, model_load(13'h041, 2'd2, 1'b0)); end
    @(posedge CLK); #1;
  endtask

  task automatic test_random();
    bit ok; logic we, u; logic [1:0] s; logic [AW-1:0] a; logic [31:0] d, er; int stall;
    for (int i = 0; i < 200; i++) begin
      we = 1'($urandom_range(0, 1)); s = 2'($urandom_range(0, 3)); u = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 47));
      d = $urandom;
      er = model_load(a, s, u);
      send(we, s, u, a, d, ok);
      checks++;
      if (!ok || (we ? LANE_WE : LANE_RE) !== exp_mask(a, s) || (we ? LANE_RE : LANE_WE) !== 4'd0 ||
          LANE_ADDR !== exp_addr(a, s) || LANE_DIN !== (we ? exp_din(a, s, d) : 32'd0)) begin
        fails++;
        $display("FAIL rnd_issue%0d: we=%b size=%0d addr=%h lwe=%h lre=%h laddr=%h din=%h need mask=%h laddr=%h din=%h",
                 i, we, s, a, LANE_WE, LANE_RE, LANE_ADDR, LANE_DIN, exp_mask(a, s), exp_addr(a, s),
                 we ? exp_din(a, s, d) : 32'd0);
      end
      if (!we) begin
        stall = $urandom_range(0, 3);
        RSP_READY = 1'b0;
        @(posedge CLK); #1;
        checks++; if (RSP_VALID !== 1'b1 || RSP_RDATA !== er) begin fails++; $display("FAIL rnd_rsp%0d: valid=%b data=%h need %h", i, RSP_VALID, RSP_RDATA, er); end
        for (int k = 0; k < stall; k++) begin
          @(posedge CLK); #1;
          checks++; if (RSP_VALID !== 1'b1 || RSP_RDATA !== er || REQ_READY !== 1'b0) begin fails++; $display("FAIL rnd_hold%0d: valid=%b data=%h ready=%b", i, RSP_VALID, RSP_RDATA, REQ_READY); end
        end
        RSP_READY = 1'b1;
        @(posedge CLK); #1;
        checks++; if (RSP_VALID !== 1'b0) begin fails++; $display("FAIL rnd_retire%0d: valid=%b need 0", i, RSP_VALID); end
      end
    end
  endtask

  task automatic test_reset_midop();
    bit ok; logic v; logic [31:0] d;
    send(1'b0, 2'd2, 1'b0, 13'h010, 32'd0, ok);
    RST_N = 1'b0;
    @(posedge CLK); #1;
    checks++; if (RSP_VALID !== 1'b0 || LANE_RE !== 4'd0 || LANE_WE !== 4'd0 || REQ_READY !== 1'b0) begin fails++; $display("FAIL midrst_in: valid=%b re=%h we=%h ready=%b", RSP_VALID, LANE_RE, LANE_WE, REQ_READY); end
    RST_N = 1'b1;
    #1;
    checks++; if (REQ_READY !== 1'b1) begin fails++; $display("FAIL midrst_ready: got %b need 1", REQ_READY); end
    @(posedge CLK); #1;
    checks++; if (RSP_VALID !== 1'b0 || RSP_RDATA !== 32'd0) begin fails++; $display("FAIL midrst_dropped: valid=%b data=%h need 0/0", RSP_VALID, RSP_RDATA); end
    send(1'b1, 2'd3, 1'b0, 13'h020, 32'hCAFEF00D, ok);
    checks++; if (!ok || LANE_WE !== 4'd0 || LANE_DIN !== 32'd0) begin fails++; $display("FAIL rsv_store: ok=%0d we=%h din=%h need 0", ok, LANE_WE, LANE_DIN); end
    run_load(2'd3, 1'b0, 13'h020, ok, v, d);
    checks++; if (!ok || v !== 1'b1 || d !== 32'd0) begin fails++; $display("FAIL rsv_load: ok=%0d valid=%b data=%h need 1/0", ok, v, d); end
    run_load(2'd2, 1'b0, 13'h020, ok, v, d);
    checks++; if (d !== model_load(13'h020, 2'd2, 1'b0)) begin fails++; $display("FAIL rsv_untouched: data=%h need %h", d, model_load(13'h020, 2'd2, 1'b0)); end
  endtask

  initial begin
    for (int b = 0; b < NB; b++) begin
      ref_mem[b] = 8'($urandom);
      bram[b % 4][b / 4] = ref_mem[b];
    end
    test_reset();
    test_aligned_word();
    test_misaligned_word();
    test_sign_extend();
    test_backpressure();
    test_wrap();
    test_back_to_back();
    test_random();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
